step_sequencer: RTL
===================

// Module: step_sequencer
// PURPOSE
//   Consumer side of the front-panel value-control interface: takes NOTE, VOLUME, BEAT_PRESCALER,
//   SEQUENCER_ENABLE and NOTE_KEY_DOWN and drives the tone generator. Idle: live pass-through of the
//   selected note while a note key is held. Run: records a note into the current step on each key
//   press and loops STEPS steps at a rate set by BEAT_PRESCALER.
// PARAMETERS
//   STEPS     16         number of sequencer steps (power of 2; STEP width = log2(STEPS))
//   TICK_DIV  1562500    CLOCK_50 cycles per base tick (31.25 ms at 50 MHz); >= 2
// PORTS
//   CLOCK_50          in   1   system clock; only clock in the block
//   RESET             in   1   synchronous, active-high reset
//   NOTE              in   4   selected note 0..12, asynchronous to CLOCK_50
//   VOLUME            in   16  amplitude word, quasi-static
//   BEAT_PRESCALER    in   5   step length in ticks minus 1, asynchronous
//   SEQUENCER_ENABLE  in   1   1 = run, 0 = idle/live; asynchronous switch
//   NOTE_KEY_DOWN     in   1   1 while either note key held; asynchronous, unbounced
//   OUT_NOTE          out  4   note to tone generator
//   OUT_VOLUME        out  16  VOLUME when NOTE_VALID, else 0
//   NOTE_VALID        out  1   tone gate
//   STEP              out  4   current step index
//   BEAT              out  1   one-cycle pulse on each step advance
// BEHAVIOUR
//   - Synchronisation: NOTE_KEY_DOWN, SEQUENCER_ENABLE, NOTE, BEAT_PRESCALER each pass 2 flops before use.
//     key_rise = synced key 0->1 (one cycle). Bus-sync glitches accepted; inputs change only on key edges.
//   - Reset: state IDLE; all step entries cleared (occupied=0, note=0); tick_cnt=0; beat_cnt=0;
//     STEP=0, OUT_NOTE=0, OUT_VOLUME=0, NOTE_VALID=0, BEAT=0. Reset wins over every other event.
//   - Step memory: STEPS entries of {occupied, note[3:0]} in registers.
//   - FSM, 2 states:
//     IDLE: OUT_NOTE=synced NOTE; NOTE_VALID=synced key; STEP=0; counters held at 0; memory untouched.
//       Synced enable=1 -> RUN with tick_cnt=0, beat_cnt=0, STEP=0; no BEAT pulse on entry.
//     RUN: tick_cnt counts 0..TICK_DIV-1 and wraps; tick = (tick_cnt==TICK_DIV-1).
//       On tick: if beat_cnt >= presc -> beat_cnt=0, STEP=STEP+1 (wraps STEPS-1 -> 0), BEAT=1 for
//       that cycle; else beat_cnt++. '>=' means lowering presc mid-step advances on the next tick.
//       Step period = (presc+1)*TICK_DIV cycles; presc=0 advances every tick.
//       key_rise: mem[STEP] <= {1, synced NOTE}, STEP = value before any same-cycle advance.
//       Outputs: OUT_NOTE=mem[STEP].note; NOTE_VALID = mem[STEP].occupied && (beat_cnt < presc || presc==0)
//       (last tick of each step is silent for articulation unless presc==0).
//       Synced enable=0 -> IDLE; STEP=0, counters cleared, memory kept.
//   - All outputs registered: reflect state/memory one cycle after it changes (note written on a
//     key_rise appears on OUT_NOTE 1 cycle later if on current step).
//   - OUT_VOLUME = NOTE_VALID ? VOLUME : 16'd0, registered alongside NOTE_VALID.
//   - Latency input pin -> output: 3 cycles (2 sync + 1 output register).
// TESTING  (TICK_DIV=4, STEPS=16)
//   1. RESET 1 cycle -> all outputs 0, STEP=0; enable=1, presc=0, no keys -> BEAT every 4 cycles,
//      STEP 0..15..0, NOTE_VALID=0 throughout.
//   2. Idle, NOTE=7, key held 10 cycles -> OUT_NOTE=7, NOTE_VALID=1, OUT_VOLUME=VOLUME, 3 cycles
//      after key edge; 0 again 3 cycles after release.
//   3. Run presc=3, key press NOTE=5 while STEP=2 -> on each return to step 2, OUT_NOTE=5,
//      NOTE_VALID high 12 cycles then low 4 cycles (16-cycle step).
//   4. key_rise on same cycle as tick advancing STEP 6->7 -> note stored in step 6; step 7 unchanged.
//   5. presc 31->0 mid-step with beat_cnt=10 -> advance on next tick, then every 4 cycles.
//   6. Enable 1->0->1 after recording -> STEP restarts at 0, recorded notes replay; RESET mid-run
//      clears memory, STEP=0, IDLE.

Source files
------------

// File: rtl/step_sequencer.sv
// Step sequencer: live note pass-through when idle, records key presses into a
// looping STEPS-entry pattern when running, clocked entirely from CLOCK_50.
module step_sequencer #(
    parameter int STEPS    = 16,
    parameter int TICK_DIV = 1562500
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET,
    input  logic [3:0]               NOTE,
    input  logic [15:0]              VOLUME,
    input  logic [4:0]               BEAT_PRESCALER,
    input  logic                     SEQUENCER_ENABLE,
    input  logic                     NOTE_KEY_DOWN,
    output logic [3:0]               OUT_NOTE,
    output logic [15:0]              OUT_VOLUME,
    output logic                     NOTE_VALID,
    output logic [$clog2(STEPS)-1:0] STEP,
    output logic                     BEAT
);

    localparam int SW = $clog2(STEPS);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic          key_s1, key_s2, key_d;
    logic          en_s1, en_s2;
    logic [3:0]    note_s1, note_s2;
    logic [4:0]    presc_s1, presc_s2;
    logic [TW-1:0] tick_cnt;
    logic [4:0]    beat_cnt;
    logic [SW-1:0] step;
    logic [STEPS-1:0] mem_occ;
    logic [3:0]    mem_note [STEPS];

    logic          key_rise;
    logic          tick;
    logic          gate;
    logic [3:0]    next_note;

    always_comb begin
        key_rise  = key_s2 & ~key_d;
        tick      = (tick_cnt == TICK_LAST);
        gate      = key_s2;
        next_note = note_s2;
        if (state == RUN) begin
            // last tick of each step is silent unless every tick is a step
            gate      = mem_occ[step] && ((beat_cnt < presc_s2) || (presc_s2 == 5'd0));
            next_note = mem_note[step];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            key_s1     <= 1'b0;
            key_s2     <= 1'b0;
            key_d      <= 1'b0;
            en_s1      <= 1'b0;
            en_s2      <= 1'b0;
            note_s1    <= '0;
            note_s2    <= '0;
            presc_s1   <= '0;
            presc_s2   <= '0;
            state      <= IDLE;
            tick_cnt   <= '0;
            beat_cnt   <= '0;
            step       <= '0;
            mem_occ    <= '0;
            for (int unsigned i = 0; i < STEPS; i++) mem_note[i] <= '0;
            OUT_NOTE   <= '0;
            OUT_VOLUME <= '0;
            NOTE_VALID <= 1'b0;
            BEAT       <= 1'b0;
        end else begin
            key_s1   <= NOTE_KEY_DOWN;
            key_s2   <= key_s1;
            key_d    <= key_s2;
            en_s1    <= SEQUENCER_ENABLE;
            en_s2    <= en_s1;
            note_s1  <= NOTE;
            note_s2  <= note_s1;
            presc_s1 <= BEAT_PRESCALER;
            presc_s2 <= presc_s1;

            OUT_NOTE   <= next_note;
            NOTE_VALID <= gate;
            OUT_VOLUME <= gate ? VOLUME : '0;
            BEAT       <= 1'b0;

            if (state == IDLE) begin
                if (en_s2) begin
                    state    <= RUN;
                    tick_cnt <= '0;
                    beat_cnt <= '0;
                    step     <= '0;
                end
            end else begin
                // recording uses the step index before any same-cycle advance
                if (key_rise) begin
                    mem_occ[step]  <= 1'b1;
                    mem_note[step] <= note_s2;
                end
                if (!en_s2) begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                    beat_cnt <= '0;
                    step     <= '0;
                end else begin
                    tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                    if (tick) begin
                        if (beat_cnt >= presc_s2) begin
                            beat_cnt <= '0;
                            step     <= step + SW'(1);
                            BEAT     <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 5'd1;
                        end
                    end
                end
            end
        end
    end

    assign STEP = step;

endmodule
